// File: rtl/volume_gain_stage.sv
// Volume gain stage: ramps the applied gain one level per accepted sample
// toward the requested level (or 0 on mute), then multiplies and saturates.
//
// Ports:
//   clk, reset_n       clock, async active-low reset (sync-safe release)
//   vol_level, mute    requested level 0..15, mute forces target 0
//   in_sample/valid    signed input stream, in_ready backpressure out
//   out_sample/valid   gained, saturated stream, out_ready from consumer
//   cur_gain           gain level currently applied

module volume_gain_stage #(
  parameter int SAMPLE_W    = 16,
  parameter int VOL_W       = 4,
  parameter int UNITY_SHIFT = 3,
  parameter int RESET_GAIN  = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [VOL_W-1:0]           vol_level,
  input  logic                       mute,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [VOL_W-1:0]           cur_gain
);

  localparam int PROD_W = SAMPLE_W + VOL_W + 1;

  logic rst_meta;
  logic rst_sync_n;
  logic run_q;

  logic                       s1_valid;
  logic signed [PROD_W-1:0]   s1_prod;
  logic                       s2_valid;
  logic signed [SAMPLE_W-1:0] s2_sample;
  logic [VOL_W-1:0]           gain_q;

  logic                       pipe_en;
  logic                       accept;
  logic [VOL_W-1:0]           target;
  logic signed [PROD_W-1:0]   in_ext;
  logic signed [PROD_W-1:0]   gain_ext;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   shifted;
  logic [PROD_W-SAMPLE_W:0]   hi;
  logic                       ovf;
  logic signed [SAMPLE_W-1:0] sat;

  // Assert passes straight through; release is retimed to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Keeps in_ready low until the internal reset has fully released.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) run_q <= 1'b0;
    else             run_q <= 1'b1;
  end

  assign pipe_en  = run_q && (!s2_valid || out_ready);
  assign in_ready = pipe_en;
  assign accept   = in_valid && pipe_en;

  assign target   = mute ? '0 : vol_level;

  assign in_ext   = PROD_W'(in_sample);
  assign gain_ext = PROD_W'({1'b0, gain_q});
  assign prod     = in_ext * gain_ext;

  // Floor shift; upper bits must be a pure sign extension to fit.
  assign shifted = s1_prod >>> UNITY_SHIFT;
  assign hi      = shifted[PROD_W-1:SAMPLE_W-1];
  assign ovf     = !((&hi) || (~|hi));

  always_comb begin
    sat = shifted[SAMPLE_W-1:0];
    if (ovf) begin
      if (shifted[PROD_W-1])
        sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
      else
        sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      s1_valid  <= 1'b0;
      s1_prod   <= '0;
      s2_valid  <= 1'b0;
      s2_sample <= '0;
      gain_q    <= VOL_W'(RESET_GAIN);
    end else begin
      if (pipe_en) begin
        s1_valid <= in_valid;
        if (in_valid) s1_prod <= prod;
        s2_valid <= s1_valid;
        if (s1_valid) s2_sample <= sat;
      end
      // Product above uses the pre-update gain.
      if (accept) begin
        if (target > gain_q)
          gain_q <= gain_q + VOL_W'(1);
        else if (target < gain_q)
          gain_q <= gain_q - VOL_W'(1);
      end
    end
  end

  assign out_sample = s2_sample;
  assign out_valid  = s2_valid;
  assign cur_gain   = gain_q;

endmodule

// File: doc/volume_gain_stage.md
Name: volume_gain_stage

Overview:
- Audio-path stage directly downstream of the volume register.
- Takes the register's 4-bit volume level (hex_vol) and applies it as a gain to the signed sample stream before the DAC/output formatter.
- Steps the applied gain one level per accepted sample toward the requested level, so volume-button presses never cause zipper clicks.
- Supports mute (fade to zero), a 2-stage multiply/saturate pipeline, and valid/ready flow control on both sides.

Parameters:
- SAMPLE_W, 16, signed audio sample width (two's complement).
- VOL_W, 4, volume level width; level 8 = unity gain.
- UNITY_SHIFT, 3, right-shift applied to the product; gain = level / 2^UNITY_SHIFT.
- RESET_GAIN, 0, applied gain after reset (0 = fade in from silence).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Vol_level  in  VOL_W  requested volume level from the volume register; unsigned, 0..15.
- Mute  in  1  level-sensitive; forces target gain to 0.
- In_sample  in  SAMPLE_W  signed input sample.
- In_valid  in  1  In_sample valid.
- In_ready  out  1  stage can accept a sample this cycle.
- Out_sample  out  SAMPLE_W  signed, gained, saturated sample.
- Out_valid  out  1  Out_sample valid.
- Out_ready  in  1  consumer accepts Out_sample this cycle.
- Cur_gain  out  VOL_W  gain currently applied (for display/debug).

Behaviour:
- Reset (async assert, sync-safe deassert inside the block):
  - Out_valid=0, Out_sample=0, Cur_gain=RESET_GAIN, both pipeline valid flags=0.
  - Any in-flight samples are discarded.
  - Asserting reset mid-operation clears Out_valid immediately, without waiting for a clock edge.
- Accept:
  - A sample is accepted when In_valid && In_ready on a rising edge.
  - In_ready = !s2_valid || Out_ready (single global pipeline enable). Combinational from Out_ready; no path from In_valid.
- Pipeline and latency:
  - Stage 1 registers the product of In_sample and {0,Cur_gain}: signed, SAMPLE_W+VOL_W+1 bits.
  - Stage 2 arithmetic-shifts the product right by UNITY_SHIFT (floor, no rounding), saturates to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], then registers Out_sample/Out_valid.
  - Latency is 2 cycles from accept to Out_valid when Out_ready=1.
  - Full throughput is one sample per clock.
- Stall:
  - When Out_valid && !Out_ready, every pipeline register holds.
  - Out_sample stays stable and In_ready=0.
  - At most 2 samples are in flight. No loss, no duplication.
  - Bubbles (In_valid=0) propagate as valid=0.
- Gain ramp:
  - target = Mute ? 0 : Vol_level.
  - On each accept, the sample is multiplied by the pre-update Cur_gain. In the same edge:
    - Cur_gain increments by 1 if target > Cur_gain.
    - Cur_gain decrements by 1 if target < Cur_gain.
    - Cur_gain is unchanged if target == Cur_gain.
  - Cur_gain never changes without an accept.
  - The change from level 0 to level 15 therefore takes 15 samples.
- Boundaries and simultaneous events:
  - Cur_gain never wraps; it is bounded to 0..15 by construction.
  - If Vol_level changes mid-ramp, the ramp retargets on the next accept.
  - Mute asserted then released before reaching 0 ramps back up from the current value.
  - Simultaneous accept and output handshake in the same cycle is legal and sustains full throughput.
- Gain 0 produces exactly 0 for every input.
- Gain 8 is bit-exact passthrough, including -32768.

Test Plan:
- Fade-in: reset, Vol_level=8, Out_ready=1, stream 10 samples of +1000.
  - Out_sample = 0,125,250,375,500,625,750,875,1000,1000.
  - Cur_gain reads 8 after the 8th accept.
  - First Out_valid appears 2 cycles after the first accept.
- Unity/extremes: with Cur_gain=8, inputs -32768, 32767, 12345, -1 come out unchanged.
- Saturation/floor: with Cur_gain=15:
  - +30000 -> 32767.
  - -30000 -> -32768.
  - -3 -> -6 (-45>>>3).
  - +3 -> 5.
- Backpressure: stream at Cur_gain=8 and hold Out_ready=0 for 6 cycles.
  - Out_valid stays 1 and Out_sample is frozen.
  - In_ready=0 once 2 samples are in flight.
  - Cur_gain does not move.
  - On release, the output sequence equals the input sequence with none dropped or repeated.
- Mute ramp: Cur_gain=8, assert Mute, stream +800.
  - Outputs 800,700,600,500,400,300,200,100,0,0.
  - Deassert Mute: the next outputs ramp 0,100,200...
- Async reset mid-stream: pull Reset_n low between clock edges while Out_valid=1.
  - Out_valid=0 and Cur_gain=0 immediately.
  - After release, the first output appears only after a new accept plus 2 cycles.
